// File: rtl/aer_rx.sv
// -----------------------------------------------------------------------------
// aer_rx -- 4-phase AER receiver with an event FIFO
//
// This block receives events from an asynchronous AER transmitter over a
// 4-phase REQ/ACK handshake. It stores each event in a small
// first-word-fall-through FIFO and presents the head event to a
// valid/ready consumer.
//
// Parameters
//   FIFO_DEPTH  event FIFO depth in entries; a power of two from 2 to 16
//
// Ports
//   CLK         system clock; all logic runs on its rising edge
//   RST         asynchronous, active-high reset
//   AERIN_REQ   4-phase request from the transmitter (asynchronous)
//   AERIN_ADDR  17-bit event address, stable while AERIN_REQ is high
//   AERIN_ACK   4-phase acknowledge, driven from a flop
//   EVT_VALID   the FIFO head holds an event
//   EVT_READY   the consumer takes the head event when EVT_VALID is high
//   EVT_TYPE    head event bit 16
//   EVT_NEUR    head event bits 15:8 (neuron index)
//   EVT_CODE    head event bits 7:0 (event code)
//   FIFO_FULL   the FIFO holds FIFO_DEPTH entries
//   EVT_CNT     16-bit count of accepted events, wraps at 0xFFFF
//               (only present when AER_RX_EVT_CNT_EN is defined)
//
// Build option
//   AER_RX_EVT_CNT_EN  adds the EVT_CNT port and its counter
// -----------------------------------------------------------------------------
module aer_rx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        AERIN_REQ,
  input  logic [16:0] AERIN_ADDR,
  output logic        AERIN_ACK,
  output logic        EVT_VALID,
  input  logic        EVT_READY,
  output logic        EVT_TYPE,
  output logic [7:0]  EVT_NEUR,
  output logic [7:0]  EVT_CODE,
  output logic        FIFO_FULL
`ifdef AER_RX_EVT_CNT_EN
  ,
  output logic [15:0] EVT_CNT
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE         = 1'b0;
  localparam logic [0:0] ST_WAIT_REQ_LOW = 1'b1;

  // Synchronizer for the asynchronous request. Only req_s_reg is used downstream.
  logic req_meta_reg;
  logic req_s_reg;

  logic [0:0]    state_reg, state_next;
  logic          ack_reg, ack_next;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_valid;

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [16:0]   mem [0:FIFO_DEPTH-1];
  logic [16:0]   head_word;

  // ---------------------------------------------------------------------------
  // Request synchronizer
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_meta_reg <= 1'b0;
      req_s_reg    <= 1'b0;
    end else begin
      req_meta_reg <= AERIN_REQ;
      req_s_reg    <= req_meta_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  // The full check uses the occupancy registered before this edge. A pop on
  // the same edge therefore frees space for the next edge, not this one.
  assign fifo_full  = (count_reg == DEPTH_CNT);
  assign fifo_valid = (count_reg != '0);
  assign pop        = fifo_valid && EVT_READY;

  always_comb begin
    state_next = state_reg;
    ack_next   = ack_reg;
    push       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_s_reg && !fifo_full) begin
          push       = 1'b1;
          ack_next   = 1'b1;
          state_next = ST_WAIT_REQ_LOW;
        end else begin
          // Backpressure: the request is held until space frees up.
          ack_next = 1'b0;
        end
      end
      ST_WAIT_REQ_LOW: begin
        if (!req_s_reg) begin
          ack_next   = 1'b0;
          state_next = ST_IDLE;
        end else begin
          ack_next = 1'b1;
        end
      end
      default: begin
        ack_next   = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= ack_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  // Storage has no reset. The reset pointers and occupancy make any stale
  // contents unreachable.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= AERIN_ADDR;
    end
  end

  // The pointers are AW bits wide, so they wrap modulo FIFO_DEPTH on their own.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // The head is masked to zero while empty. The event fields therefore read
  // 0 after reset, even though the storage itself is never cleared.
  assign head_word = fifo_valid ? mem[rd_ptr_reg] : 17'h0_0000;

  assign AERIN_ACK = ack_reg;
  assign EVT_VALID = fifo_valid;
  assign FIFO_FULL = fifo_full;
  assign EVT_TYPE  = head_word[16];
  assign EVT_NEUR  = head_word[15:8];
  assign EVT_CODE  = head_word[7:0];

`ifdef AER_RX_EVT_CNT_EN
  // ---------------------------------------------------------------------------
  // Accepted-event counter (one increment per FIFO push)
  // ---------------------------------------------------------------------------
  logic [15:0] evt_cnt_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      evt_cnt_reg <= 16'h0000;
    end else if (push) begin
      evt_cnt_reg <= evt_cnt_reg + 16'h0001;
    end
  end

  assign EVT_CNT = evt_cnt_reg;
`endif

endmodule

// File: tb/tb_aer_rx.sv
// -----------------------------------------------------------------------------
// tb_aer_rx -- self-checking bench for aer_rx (FIFO_DEPTH = 4)
//
// A transmitter model drives 4-phase handshakes. Each event it offers is
// pushed to a scoreboard queue. A monitor pops the queue whenever the DUT
// hands an event to the consumer and compares the two.
// -----------------------------------------------------------------------------
module tb_aer_rx;

  logic        CLK;
  logic        RST;
  logic        AERIN_REQ;
  logic [16:0] AERIN_ADDR;
  logic        AERIN_ACK;
  logic        EVT_VALID;
  logic        EVT_READY;
  logic        EVT_TYPE;
  logic [7:0]  EVT_NEUR;
  logic [7:0]  EVT_CODE;
  logic        FIFO_FULL;
`ifdef AER_RX_EVT_CNT_EN
  logic [15:0] EVT_CNT;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  logic [16:0] exp_q[$];
  logic [15:0] exp_cnt = 16'h0000;
  logic        prod_done;

  aer_rx #(.FIFO_DEPTH(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .AERIN_REQ  (AERIN_REQ),
    .AERIN_ADDR (AERIN_ADDR),
    .AERIN_ACK  (AERIN_ACK),
    .EVT_VALID  (EVT_VALID),
    .EVT_READY  (EVT_READY),
    .EVT_TYPE   (EVT_TYPE),
    .EVT_NEUR   (EVT_NEUR),
    .EVT_CODE   (EVT_CODE),
    .FIFO_FULL  (FIFO_FULL)
`ifdef AER_RX_EVT_CNT_EN
    ,
    .EVT_CNT    (EVT_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Consumer-side monitor: a pop happens on the coming rising edge.
  always @(negedge CLK) begin
    if (!RST && EVT_VALID && EVT_READY) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_evt", 32'(exp_q.size()), 32'd1);
      end else begin
        check("sb_evt", {15'd0, EVT_TYPE, EVT_NEUR, EVT_CODE}, {15'd0, exp_q.pop_front()});
      end
      n_pop++;
    end
  end

  task automatic send_event(input logic [16:0] addr);
    int w;
    AERIN_ADDR = addr;
    AERIN_REQ  = 1'b1;
    exp_q.push_back(addr);
    exp_cnt++;
    w = 0;
    while (!AERIN_ACK && w < 200) begin tick(); w++; end
    check("ack_rise", {31'd0, AERIN_ACK}, 32'd1);
    AERIN_REQ = 1'b0;
    w = 0;
    while (AERIN_ACK && w < 40) begin tick(); w++; end
    check("ack_fall", {31'd0, AERIN_ACK}, 32'd0);
  endtask

  task automatic wait_ack(input logic level, input string tag);
    int w;
    w = 0;
    while (AERIN_ACK !== level && w < 40) begin tick(); w++; end
    check(tag, {31'd0, AERIN_ACK}, {31'd0, level});
  endtask

  task automatic drain(input int expect_n);
    int start;
    int w;
    start = n_pop;
    w = 0;
    EVT_READY = 1'b1;
    while (EVT_VALID && w < 100) begin tick(); w++; end
    EVT_READY = 1'b0;
    check("drain_cnt", 32'(n_pop - start), 32'(expect_n));
  endtask

  initial begin
    logic [16:0] held;
    int start_pop;

    RST        = 1'b1;
    AERIN_REQ  = 1'b0;
    AERIN_ADDR = 17'h0;
    EVT_READY  = 1'b0;
    prod_done  = 1'b0;
    tick(); tick();

    // ---- reset state ----
    check("rst_ack",   {31'd0, AERIN_ACK}, 32'd0);
    check("rst_valid", {31'd0, EVT_VALID}, 32'd0);
    check("rst_full",  {31'd0, FIFO_FULL}, 32'd0);
    check("rst_evt",   {15'd0, EVT_TYPE, EVT_NEUR, EVT_CODE}, 32'd0);
`ifdef AER_RX_EVT_CNT_EN
    check("rst_cnt",   {16'd0, EVT_CNT}, 32'd0);
`endif
    RST = 1'b0;
    tick();

    // ---- single event with latency ----
    AERIN_ADDR = 17'h0_05_07;
    AERIN_REQ  = 1'b1;
    exp_q.push_back(17'h0_05_07);
    exp_cnt++;
    tick(); tick();
    check("lat_ack_early", {31'd0, AERIN_ACK}, 32'd0);
    check("lat_valid_early", {31'd0, EVT_VALID}, 32'd0);
    tick();
    check("lat_ack", {31'd0, AERIN_ACK}, 32'd1);
    check("lat_valid", {31'd0, EVT_VALID}, 32'd1);
    check("single_type", {31'd0, EVT_TYPE}, 32'd0);
    check("single_neur", {24'd0, EVT_NEUR}, 32'h05);
    check("single_code", {24'd0, EVT_CODE}, 32'h07);
    AERIN_REQ = 1'b0;
    tick(); tick();
    check("drop_ack_hold", {31'd0, AERIN_ACK}, 32'd1);
    tick();
    check("drop_ack_low", {31'd0, AERIN_ACK}, 32'd0);
    drain(1);

    // ---- backpressure ----
    for (int i = 0; i < 4; i++) send_event({1'b0, 8'h10 + 8'(i), 8'hA0 + 8'(i)});
    check("bp_full", {31'd0, FIFO_FULL}, 32'd1);
    AERIN_ADDR = 17'h1_14_A4;
    AERIN_REQ  = 1'b1;
    exp_q.push_back(17'h1_14_A4);
    exp_cnt++;
    repeat (10) tick();
    check("bp_hold_ack", {31'd0, AERIN_ACK}, 32'd0);
    check("bp_hold_full", {31'd0, FIFO_FULL}, 32'd1);
    EVT_READY = 1'b1;
    tick();
    EVT_READY = 1'b0;
    check("bp_same_edge_ack", {31'd0, AERIN_ACK}, 32'd0);
    tick();
    check("bp_ack_after_pop", {31'd0, AERIN_ACK}, 32'd1);
    check("bp_refull", {31'd0, FIFO_FULL}, 32'd1);
    AERIN_REQ = 1'b0;
    wait_ack(1'b0, "bp_ack_fall");
    drain(4);

    // ---- ordering with random consumer ----
    start_pop = n_pop;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send_event({1'($urandom_range(1, 0)), 8'(i), 8'($urandom_range(255, 0))});
        prod_done = 1'b1;
      end
      begin
        for (int c = 0; c < 3000; c++) begin
          EVT_READY = 1'($urandom_range(1, 0));
          tick();
          if (prod_done && !EVT_VALID) break;
        end
        EVT_READY = 1'b0;
      end
    join
    check("order_cnt", 32'(n_pop - start_pop), 32'd10);

    // ---- simultaneous push and pop at occupancy 2 ----
    send_event(17'h0_20_01);
    send_event(17'h0_21_02);
    AERIN_ADDR = 17'h0_22_03;
    AERIN_REQ  = 1'b1;
    exp_q.push_back(17'h0_22_03);
    exp_cnt++;
    tick(); tick();
    EVT_READY = 1'b1;
    tick();
    EVT_READY = 1'b0;
    check("pp_ack", {31'd0, AERIN_ACK}, 32'd1);
    check("pp_full", {31'd0, FIFO_FULL}, 32'd0);
    AERIN_REQ = 1'b0;
    wait_ack(1'b0, "pp_ack_fall");
    send_event(17'h0_23_04);
    check("pp_occ3_full", {31'd0, FIFO_FULL}, 32'd0);
    send_event(17'h0_24_05);
    check("pp_occ4_full", {31'd0, FIFO_FULL}, 32'd1);
    drain(4);

    // ---- reset mid-handshake ----
    send_event(17'h0_30_11);
    held       = 17'h1_31_12;
    AERIN_ADDR = held;
    AERIN_REQ  = 1'b1;
    exp_q.push_back(held);
    exp_cnt++;
    wait_ack(1'b1, "mr_ack_before");
    RST = 1'b1;
    #1;
    check("mr_ack", {31'd0, AERIN_ACK}, 32'd0);
    check("mr_valid", {31'd0, EVT_VALID}, 32'd0);
    check("mr_full", {31'd0, FIFO_FULL}, 32'd0);
`ifdef AER_RX_EVT_CNT_EN
    check("mr_cnt", {16'd0, EVT_CNT}, 32'd0);
`endif
    exp_q.delete();
    exp_q.push_back(held);
    exp_cnt = 16'h0001;
    tick(); tick();
    RST = 1'b0;
    wait_ack(1'b1, "mr_reaccept");
    AERIN_REQ = 1'b0;
    wait_ack(1'b0, "mr_ack_fall");
    drain(1);

`ifdef AER_RX_EVT_CNT_EN
    send_event(17'h0_40_00);
    send_event(17'h0_41_00);
    drain(2);
    check("evt_cnt", {16'd0, EVT_CNT}, {16'd0, exp_cnt});
`endif

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
